// File: rtl/reservation_station_pkg.sv
// Shared constants, opcode encoding and operand snooping helper for the reservation station.
package reservation_station_pkg;

    localparam int unsigned RsSizeDef = 16;
    localparam int unsigned RsIdxW    = 4;
    localparam int unsigned RobIdW    = 4;
    localparam int unsigned XLen      = 32;
    localparam int unsigned OpW       = 6;

    typedef enum logic [OpW-1:0] {
        OpNop, OpAdd, OpSub, OpSll, OpSlt, OpSltu, OpXor, OpSrl, OpSra, OpOr, OpAnd,
        OpAddi, OpSlti, OpSltiu, OpXori, OpOri, OpAndi, OpSlli, OpSrli, OpSrai,
        OpBeq, OpBne, OpBlt, OpBge, OpBltu, OpBgeu, OpJalr, OpLtype, OpStype
    } opcode_e;

    typedef struct packed {
        logic            rdy;
        logic [XLen-1:0] val;
    } operand_t;

    // Resolve a pending operand against both CDBs; bus A wins if both match the same tag.
    function automatic operand_t snoop(
        input operand_t          op,
        input logic              a_sgn,
        input logic [RobIdW-1:0] a_tag,
        input logic [XLen-1:0]   a_res,
        input logic              d_sgn,
        input logic [RobIdW-1:0] d_tag,
        input logic [XLen-1:0]   d_res
    );
        operand_t res;
        res = op;
        if (!op.rdy) begin
            if (a_sgn && (a_tag == op.val[RobIdW-1:0])) begin
                res.rdy = 1'b1;
                res.val = a_res;
            end else if (d_sgn && (d_tag == op.val[RobIdW-1:0])) begin
                res.rdy = 1'b1;
                res.val = d_res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Issue, CDB and ALU dispatch signals of the reservation station.
interface reservation_station_if;
    import reservation_station_pkg::*;

    logic              issue_sgn;
    logic [OpW-1:0]    issue_opcode;
    logic [XLen-1:0]   issue_rs1_val;
    logic              issue_rs1_rdy;
    logic [XLen-1:0]   issue_rs2_val;
    logic              issue_rs2_rdy;
    logic [RobIdW-1:0] issue_rob_name;

    logic              cdba_sgn;
    logic [RobIdW-1:0] cdba_rob_name;
    logic [XLen-1:0]   cdba_result;
    logic              cdbd_sgn;
    logic [RobIdW-1:0] cdbd_rob_name;
    logic [XLen-1:0]   cdbd_result;

    logic              alu_sgn;
    logic [OpW-1:0]    alu_opcode;
    logic [XLen-1:0]   alu_v1;
    logic [XLen-1:0]   alu_v2;
    logic [RobIdW-1:0] alu_rob_name;

    // Environment side: issue stage, CDB producers and ALU consumer.
    modport master (
        output issue_sgn, issue_opcode, issue_rs1_val, issue_rs1_rdy, issue_rs2_val,
               issue_rs2_rdy, issue_rob_name,
        output cdba_sgn, cdba_rob_name, cdba_result, cdbd_sgn, cdbd_rob_name, cdbd_result,
        input  alu_sgn, alu_opcode, alu_v1, alu_v2, alu_rob_name
    );

    // Reservation station side.
    modport slave (
        input  issue_sgn, issue_opcode, issue_rs1_val, issue_rs1_rdy, issue_rs2_val,
               issue_rs2_rdy, issue_rob_name,
        input  cdba_sgn, cdba_rob_name, cdba_result, cdbd_sgn, cdbd_rob_name, cdbd_result,
        output alu_sgn, alu_opcode, alu_v1, alu_v2, alu_rob_name
    );

endinterface

// File: rtl/reservation_station_prio_enc.sv
// Lowest-index priority encoder: returns the first set bit and whether any bit is set.
module reservation_station_prio_enc #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 4
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    // Scan high to low so the lowest set bit is the last one written.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Out-of-order operand buffer between issue and the ALU, with CDB wakeup and flush.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int unsigned RS_SIZE = RsSizeDef,
    parameter int unsigned RS_W    = RsIdxW,
    parameter int unsigned ROB_W   = RobIdW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy_i,
    input  logic                 clr_i,
    output logic                 full_o,
    reservation_station_if.slave rs_if
);

    localparam int unsigned CntW = RS_W + 1;

    logic [RS_SIZE-1:0] busy_q, busy_d, r1_q, r1_d, r2_q, r2_d;
    logic [OpW-1:0]     opcode_q [RS_SIZE];
    logic [OpW-1:0]     opcode_d [RS_SIZE];
    logic [XLen-1:0]    v1_q     [RS_SIZE];
    logic [XLen-1:0]    v1_d     [RS_SIZE];
    logic [XLen-1:0]    v2_q     [RS_SIZE];
    logic [XLen-1:0]    v2_d     [RS_SIZE];
    logic [ROB_W-1:0]   rob_q    [RS_SIZE];
    logic [ROB_W-1:0]   rob_d    [RS_SIZE];
    logic [CntW-1:0]    count_q, count_d;

    logic               alu_sgn_q, alu_sgn_d;
    logic [OpW-1:0]     alu_opcode_q, alu_opcode_d;
    logic [XLen-1:0]    alu_v1_q, alu_v1_d, alu_v2_q, alu_v2_d;
    logic [ROB_W-1:0]   alu_rob_q, alu_rob_d;

    logic [RS_W-1:0]    free_idx, ready_idx;
    logic               free_found, ready_found;

    reservation_station_prio_enc #(.N(RS_SIZE), .W(RS_W)) u_free_enc (
        .req_i   (~busy_q),
        .idx_o   (free_idx),
        .found_o (free_found)
    );

    // Ready search uses registered state only, so a wakeup needs one more edge to dispatch.
    reservation_station_prio_enc #(.N(RS_SIZE), .W(RS_W)) u_ready_enc (
        .req_i   (busy_q & r1_q & r2_q),
        .idx_o   (ready_idx),
        .found_o (ready_found)
    );

    // Full leaves one slot of slack for the entry latched inside issue.
    assign full_o = (count_q >= CntW'(RS_SIZE - 1));

    assign rs_if.alu_sgn      = alu_sgn_q;
    assign rs_if.alu_opcode   = alu_opcode_q;
    assign rs_if.alu_v1       = alu_v1_q;
    assign rs_if.alu_v2       = alu_v2_q;
    assign rs_if.alu_rob_name = alu_rob_q;

    // Next state: wakeup, dispatch, allocation and count; flush discards all of it.
    always_comb begin
        operand_t op;
        logic     issue_ok;
        busy_d       = busy_q;
        r1_d         = r1_q;
        r2_d         = r2_q;
        opcode_d     = opcode_q;
        v1_d         = v1_q;
        v2_d         = v2_q;
        rob_d        = rob_q;
        count_d      = count_q;
        alu_sgn_d    = alu_sgn_q;
        alu_opcode_d = alu_opcode_q;
        alu_v1_d     = alu_v1_q;
        alu_v2_d     = alu_v2_q;
        alu_rob_d    = alu_rob_q;
        op           = '0;
        issue_ok     = rs_if.issue_sgn && free_found;
        if (rdy_i) begin
            if (clr_i) begin
                busy_d    = '0;
                count_d   = '0;
                alu_sgn_d = 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy_q[i]) begin
                        op = snoop({r1_q[i], v1_q[i]}, rs_if.cdba_sgn, rs_if.cdba_rob_name,
                                   rs_if.cdba_result, rs_if.cdbd_sgn, rs_if.cdbd_rob_name,
                                   rs_if.cdbd_result);
                        r1_d[i] = op.rdy;
                        v1_d[i] = op.val;
                        op = snoop({r2_q[i], v2_q[i]}, rs_if.cdba_sgn, rs_if.cdba_rob_name,
                                   rs_if.cdba_result, rs_if.cdbd_sgn, rs_if.cdbd_rob_name,
                                   rs_if.cdbd_result);
                        r2_d[i] = op.rdy;
                        v2_d[i] = op.val;
                    end
                end
                alu_sgn_d = ready_found;
                if (ready_found) begin
                    alu_opcode_d      = opcode_q[ready_idx];
                    alu_v1_d          = v1_q[ready_idx];
                    alu_v2_d          = v2_q[ready_idx];
                    alu_rob_d         = rob_q[ready_idx];
                    busy_d[ready_idx] = 1'b0;
                end
                // free_idx comes from busy_q, so it never aliases the slot freed this edge.
                if (issue_ok) begin
                    op = snoop({rs_if.issue_rs1_rdy, rs_if.issue_rs1_val}, rs_if.cdba_sgn,
                               rs_if.cdba_rob_name, rs_if.cdba_result, rs_if.cdbd_sgn,
                               rs_if.cdbd_rob_name, rs_if.cdbd_result);
                    r1_d[free_idx] = op.rdy;
                    v1_d[free_idx] = op.val;
                    op = snoop({rs_if.issue_rs2_rdy, rs_if.issue_rs2_val}, rs_if.cdba_sgn,
                               rs_if.cdba_rob_name, rs_if.cdba_result, rs_if.cdbd_sgn,
                               rs_if.cdbd_rob_name, rs_if.cdbd_result);
                    r2_d[free_idx]     = op.rdy;
                    v2_d[free_idx]     = op.val;
                    busy_d[free_idx]   = 1'b1;
                    opcode_d[free_idx] = rs_if.issue_opcode;
                    rob_d[free_idx]    = rs_if.issue_rob_name;
                end
                if (issue_ok && !ready_found) begin
                    count_d = count_q + CntW'(1);
                end else if (!issue_ok && ready_found) begin
                    count_d = count_q - CntW'(1);
                end
            end
        end
    end

    // State registers; entry payloads are qualified by busy and need no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q       <= '0;
            r1_q         <= '0;
            r2_q         <= '0;
            count_q      <= '0;
            alu_sgn_q    <= 1'b0;
            alu_opcode_q <= '0;
            alu_v1_q     <= '0;
            alu_v2_q     <= '0;
            alu_rob_q    <= '0;
        end else begin
            busy_q       <= busy_d;
            r1_q         <= r1_d;
            r2_q         <= r2_d;
            opcode_q     <= opcode_d;
            v1_q         <= v1_d;
            v2_q         <= v2_d;
            rob_q        <= rob_d;
            count_q      <= count_d;
            alu_sgn_q    <= alu_sgn_d;
            alu_opcode_q <= alu_opcode_d;
            alu_v1_q     <= alu_v1_d;
            alu_v2_q     <= alu_v2_d;
            alu_rob_q    <= alu_rob_d;
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed self-checking bench for the reservation station.
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic clk;
    logic rst;
    logic rdy;
    logic clr;
    logic full;
    int   n_checks;
    int   n_errors;

    reservation_station_if rs_if ();

    reservation_station dut (
        .clk    (clk),
        .rst    (rst),
        .rdy_i  (rdy),
        .clr_i  (clr),
        .full_o (full),
        .rs_if  (rs_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] v1, input logic r1,
                         input logic [31:0] v2, input logic r2, input logic [3:0] rob);
        rs_if.issue_sgn      = 1'b1;
        rs_if.issue_opcode   = op;
        rs_if.issue_rs1_val  = v1;
        rs_if.issue_rs1_rdy  = r1;
        rs_if.issue_rs2_val  = v2;
        rs_if.issue_rs2_rdy  = r2;
        rs_if.issue_rob_name = rob;
    endtask

    task automatic no_issue();
        rs_if.issue_sgn = 1'b0;
    endtask

    task automatic cdba(input logic sgn, input logic [3:0] tag, input logic [31:0] res);
        rs_if.cdba_sgn      = sgn;
        rs_if.cdba_rob_name = tag;
        rs_if.cdba_result   = res;
    endtask

    task automatic cdbd(input logic sgn, input logic [3:0] tag, input logic [31:0] res);
        rs_if.cdbd_sgn      = sgn;
        rs_if.cdbd_rob_name = tag;
        rs_if.cdbd_result   = res;
    endtask

    // Issuing into a station that reports full is a protocol error of this bench.
    always @(negedge clk) begin
        if (!rst && rdy && !clr && rs_if.issue_sgn) begin
            check("issue_while_full", {31'd0, full}, 32'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        rdy = 1'b1;
        clr = 1'b0;
        issue(6'd0, 32'd0, 1'b0, 32'd0, 1'b0, 4'd0);
        no_issue();
        cdba(1'b0, 4'd0, 32'd0);
        cdbd(1'b0, 4'd0, 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_sgn", {31'd0, rs_if.alu_sgn}, 32'd0);
        check("rst_opcode", {26'd0, rs_if.alu_opcode}, 32'd0);
        check("rst_v1", rs_if.alu_v1, 32'd0);
        check("rst_v2", rs_if.alu_v2, 32'd0);
        check("rst_rob", {28'd0, rs_if.alu_rob_name}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);

        // Both operands ready: dispatch two edges after issue
        issue(OpAdd, 32'd5, 1'b1, 32'd7, 1'b1, 4'd3);
        tick();
        no_issue();
        check("t1_lat", {31'd0, rs_if.alu_sgn}, 32'd0);
        tick();
        check("t1_sgn", {31'd0, rs_if.alu_sgn}, 32'd1);
        check("t1_op", {26'd0, rs_if.alu_opcode}, {26'd0, OpAdd});
        check("t1_v1", rs_if.alu_v1, 32'd5);
        check("t1_v2", rs_if.alu_v2, 32'd7);
        check("t1_rob", {28'd0, rs_if.alu_rob_name}, 32'd3);
        tick();
        check("t1_once", {31'd0, rs_if.alu_sgn}, 32'd0);
        check("t1_full", {31'd0, full}, 32'd0);

        // Pending rs1 (upper tag bits are junk) woken by CDBA
        issue(OpSub, 32'hFFFF_FFF6, 1'b0, 32'd1, 1'b1, 4'd4);
        tick();
        no_issue();
        tick();
        check("t2_wait", {31'd0, rs_if.alu_sgn}, 32'd0);
        cdba(1'b1, 4'd6, 32'h10);
        tick();
        cdba(1'b0, 4'd0, 32'd0);
        check("t2_wake_lat", {31'd0, rs_if.alu_sgn}, 32'd0);
        tick();
        check("t2_sgn", {31'd0, rs_if.alu_sgn}, 32'd1);
        check("t2_op", {26'd0, rs_if.alu_opcode}, {26'd0, OpSub});
        check("t2_v1", rs_if.alu_v1, 32'h10);
        check("t2_v2", rs_if.alu_v2, 32'd1);
        check("t2_rob", {28'd0, rs_if.alu_rob_name}, 32'd4);
        tick();

        // Same-cycle CDBD forwarding at issue
        issue(OpXor, 32'd3, 1'b1, 32'd2, 1'b0, 4'd5);
        cdbd(1'b1, 4'd2, 32'hABCD);
        tick();
        no_issue();
        cdbd(1'b0, 4'd0, 32'd0);
        check("t3_lat", {31'd0, rs_if.alu_sgn}, 32'd0);
        tick();
        check("t3_sgn", {31'd0, rs_if.alu_sgn}, 32'd1);
        check("t3_v1", rs_if.alu_v1, 32'd3);
        check("t3_v2", rs_if.alu_v2, 32'hABCD);
        check("t3_rob", {28'd0, rs_if.alu_rob_name}, 32'd5);
        tick();

        // Fill 15 pending entries, full threshold, then drain
        for (int i = 0; i < 15; i++) begin
            issue(OpBeq, (i == 0) ? 32'd1 : 32'd8, 1'b0, 32'(i), 1'b1, 4'(i));
            tick();
            if (i == 13) check("t4_not_full_14", {31'd0, full}, 32'd0);
        end
        no_issue();
        check("t4_full_15", {31'd0, full}, 32'd1);
        cdba(1'b1, 4'd1, 32'h77);
        tick();
        cdba(1'b0, 4'd0, 32'd0);
        check("t4_wake_full", {31'd0, full}, 32'd1);
        check("t4_wake_sgn", {31'd0, rs_if.alu_sgn}, 32'd0);
        tick();
        check("t4_old_sgn", {31'd0, rs_if.alu_sgn}, 32'd1);
        check("t4_old_rob", {28'd0, rs_if.alu_rob_name}, 32'd0);
        check("t4_old_v1", rs_if.alu_v1, 32'h77);
        check("t4_full_drop", {31'd0, full}, 32'd0);
        cdbd(1'b1, 4'd8, 32'd5);
        tick();
        cdbd(1'b0, 4'd0, 32'd0);
        for (int i = 1; i < 15; i++) begin
            tick();
            check("t4_drain_sgn", {31'd0, rs_if.alu_sgn}, 32'd1);
            check("t4_drain_rob", {28'd0, rs_if.alu_rob_name}, 32'(i));
            check("t4_drain_v2", rs_if.alu_v2, 32'(i));
        end
        tick();
        check("t4_empty_sgn", {31'd0, rs_if.alu_sgn}, 32'd0);
        check("t4_empty_full", {31'd0, full}, 32'd0);

        // rdy low freezes outputs and holds back a ready entry
        issue(OpAnd, 32'd9, 1'b1, 32'd1, 1'b1, 4'd9);
        tick();
        no_issue();
        tick();
        check("rdy_pre_rob", {28'd0, rs_if.alu_rob_name}, 32'd9);
        issue(OpOr, 32'd1, 1'b1, 32'd1, 1'b1, 4'd10);
        tick();
        no_issue();
        rdy = 1'b0;
        tick();
        tick();
        check("rdy_hold_sgn", {31'd0, rs_if.alu_sgn}, 32'd0);
        rdy = 1'b1;
        tick();
        check("rdy_resume_sgn", {31'd0, rs_if.alu_sgn}, 32'd1);
        check("rdy_resume_rob", {28'd0, rs_if.alu_rob_name}, 32'd10);
        tick();

        // Flush with 8 entries and a same-cycle issue
        for (int i = 0; i < 8; i++) begin
            issue(OpAddi, (i < 4) ? 32'd12 : 32'(i), (i < 4) ? 1'b0 : 1'b1, 32'd0, 1'b1, 4'(i));
            tick();
        end
        issue(OpAddi, 32'd1, 1'b1, 32'd1, 1'b1, 4'd13);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        no_issue();
        check("clr_sgn", {31'd0, rs_if.alu_sgn}, 32'd0);
        check("clr_full", {31'd0, full}, 32'd0);
        tick();
        check("clr_drop_issue", {31'd0, rs_if.alu_sgn}, 32'd0);
        cdba(1'b1, 4'd12, 32'h99);
        tick();
        cdba(1'b0, 4'd0, 32'd0);
        tick();
        check("clr_stale_a", {31'd0, rs_if.alu_sgn}, 32'd0);
        tick();
        check("clr_stale_b", {31'd0, rs_if.alu_sgn}, 32'd0);
        // Count restarted from zero: full appears exactly at the 15th entry
        for (int i = 0; i < 15; i++) begin
            issue(OpSlt, 32'd3, 1'b0, 32'd0, 1'b1, 4'(i));
            tick();
            if (i == 13) check("clr_cnt_14", {31'd0, full}, 32'd0);
        end
        no_issue();
        check("clr_cnt_15", {31'd0, full}, 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr2_full", {31'd0, full}, 32'd0);

        // Index priority and lowest-free allocation
        issue(OpOr, 32'd7, 1'b0, 32'd1, 1'b1, 4'd1);
        tick();
        issue(OpOr, 32'd7, 1'b0, 32'd2, 1'b1, 4'd2);
        tick();
        no_issue();
        cdba(1'b1, 4'd7, 32'h42);
        tick();
        cdba(1'b0, 4'd0, 32'd0);
        check("t6_wake_sgn", {31'd0, rs_if.alu_sgn}, 32'd0);
        issue(OpOr, 32'h11, 1'b1, 32'h22, 1'b1, 4'd3);
        tick();
        check("t6_d0_rob", {28'd0, rs_if.alu_rob_name}, 32'd1);
        check("t6_d0_v1", rs_if.alu_v1, 32'h42);
        issue(OpSlt, 32'd1, 1'b1, 32'd2, 1'b1, 4'd4);
        tick();
        no_issue();
        check("t6_d1_rob", {28'd0, rs_if.alu_rob_name}, 32'd2);
        tick();
        check("t6_lowest_free", {28'd0, rs_if.alu_rob_name}, 32'd4);
        check("t6_d2_op", {26'd0, rs_if.alu_opcode}, {26'd0, OpSlt});
        tick();
        check("t6_d3_rob", {28'd0, rs_if.alu_rob_name}, 32'd3);
        check("t6_d3_v2", rs_if.alu_v2, 32'h22);
        tick();
        check("t6_idle_sgn", {31'd0, rs_if.alu_sgn}, 32'd0);
        check("t6_idle_full", {31'd0, full}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
